regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (WE3/A3/WD3) between the main writeback path and the multi-cycle unit (MUL/DIV) result path. Keeps a 15-entry pending scoreboard for the destination of an in-flight multi-cycle op. Stalls issue on any read or write hazard against that destination. Buffers a colliding multi-cycle result in a one-entry hold register until the port is free, with a starvation guard.

---
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between main writeback and the multi-cycle unit
// Tracks the in-flight multi-cycle destination, stalls decode on hazards, and holds a colliding result.
module regfile_wb_arbiter #(
  parameter int MAX_HOLD   = 4,
  parameter int HOLD_CNT_W = 3
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        WB_WE,
  input  logic [3:0]  WB_A,
  input  logic [31:0] WB_D,
  input  logic        MC_Start,
  input  logic [3:0]  MC_Rd,
  input  logic        MC_Done,
  input  logic [31:0] MC_Result,
  input  logic [3:0]  ID_A1,
  input  logic        ID_RE1,
  input  logic [3:0]  ID_A2,
  input  logic        ID_RE2,
  input  logic [3:0]  ID_Wr,
  input  logic        ID_WE,
  output logic        WE3,
  output logic [3:0]  A3,
  output logic [31:0] WD3,
  output logic        Stall,
  output logic        MC_Busy,
  output logic        Err
);

  localparam logic [HOLD_CNT_W-1:0] AGE_MAX = HOLD_CNT_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [3:0]            rd_q, rd_n;
  logic [14:0]           pending, pending_n;
  logic [31:0]           hold_d, hold_d_n;
  logic [HOLD_CNT_W-1:0] hold_age, hold_age_n;
  logic                  err_n;

  logic        port_free;
  logic        main_write;
  logic [15:0] pend_ext;
  logic [14:0] rd_mask;
  logic [14:0] start_mask;

  assign port_free  = !WB_WE || (WB_A == 4'd15);
  assign main_write = WB_WE && (WB_A != 4'd15);
  assign pend_ext   = {1'b0, pending};
  // R15 is never tracked, so its mask is empty
  assign rd_mask    = (rd_q == 4'd15) ? 15'd0 : (15'd1 << rd_q);
  assign start_mask = (MC_Rd == 4'd15) ? 15'd0 : (15'd1 << MC_Rd);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= IDLE;
      rd_q     <= 4'd0;
      pending  <= 15'd0;
      hold_d   <= 32'd0;
      hold_age <= '0;
      Err      <= 1'b0;
    end else begin
      state    <= state_n;
      rd_q     <= rd_n;
      pending  <= pending_n;
      hold_d   <= hold_d_n;
      hold_age <= hold_age_n;
      Err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    rd_n       = rd_q;
    pending_n  = pending;
    hold_d_n   = hold_d;
    hold_age_n = hold_age;
    err_n      = 1'b0;
    WE3        = 1'b0;
    A3         = 4'd0;
    WD3        = 32'd0;

    if (main_write) begin
      WE3 = 1'b1;
      A3  = WB_A;
      WD3 = WB_D;
    end

    unique case (state)
      IDLE: begin
        if (MC_Start) begin
          state_n   = BUSY;
          rd_n      = MC_Rd;
          pending_n = pending | start_mask;
        end
        if (MC_Done) err_n = 1'b1;
      end
      BUSY: begin
        if (MC_Start) err_n = 1'b1;
        if (MC_Done) begin
          if (port_free) begin
            if (rd_q != 4'd15) begin
              WE3 = 1'b1;
              A3  = rd_q;
              WD3 = MC_Result;
            end
            pending_n = pending & ~rd_mask;
            state_n   = IDLE;
          end else begin
            hold_d_n   = MC_Result;
            hold_age_n = '0;
            state_n    = HOLD;
          end
        end
      end
      HOLD: begin
        if (MC_Start) err_n = 1'b1;
        if (port_free) begin
          if (rd_q != 4'd15) begin
            WE3 = 1'b1;
            A3  = rd_q;
            WD3 = hold_d;
          end
          pending_n = pending & ~rd_mask;
          state_n   = IDLE;
        end else if (hold_age < AGE_MAX) begin
          hold_age_n = hold_age + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (Reset) begin
      WE3 = 1'b0;
      A3  = 4'd0;
      WD3 = 32'd0;
    end
  end

  // Pending clears on the writing edge, so Stall covers the write cycle itself
  always_comb begin
    Stall = 1'b0;
    if (!Reset) begin
      Stall = (ID_RE1 && pend_ext[ID_A1]) ||
              (ID_RE2 && pend_ext[ID_A2]) ||
              (ID_WE  && pend_ext[ID_Wr]) ||
              ((state == HOLD) && (hold_age >= AGE_MAX));
    end
  end

  assign MC_Busy = !Reset && (state != IDLE);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
// Inputs change 1ns after a rising edge; combinational outputs are checked mid-cycle.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        WB_WE;
  logic [3:0]  WB_A;
  logic [31:0] WB_D;
  logic        MC_Start;
  logic [3:0]  MC_Rd;
  logic        MC_Done;
  logic [31:0] MC_Result;
  logic [3:0]  ID_A1, ID_A2, ID_Wr;
  logic        ID_RE1, ID_RE2, ID_WE;
  logic        WE3;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        Stall, MC_Busy, Err;

  int compared = 0;
  int mismatched = 0;

  regfile_wb_arbiter #(.MAX_HOLD(4), .HOLD_CNT_W(3)) dut (
    .CLK(CLK), .Reset(Reset),
    .WB_WE(WB_WE), .WB_A(WB_A), .WB_D(WB_D),
    .MC_Start(MC_Start), .MC_Rd(MC_Rd), .MC_Done(MC_Done), .MC_Result(MC_Result),
    .ID_A1(ID_A1), .ID_RE1(ID_RE1), .ID_A2(ID_A2), .ID_RE2(ID_RE2),
    .ID_Wr(ID_Wr), .ID_WE(ID_WE),
    .WE3(WE3), .A3(A3), .WD3(WD3), .Stall(Stall), .MC_Busy(MC_Busy), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, WE3}, {31'd0, we});
    chk({tag, "_a"}, {28'd0, A3}, {28'd0, a});
    chk({tag, "_d"}, WD3, d);
  endtask

  task automatic clear_id();
    ID_A1 = 4'd0; ID_RE1 = 1'b0;
    ID_A2 = 4'd0; ID_RE2 = 1'b0;
    ID_Wr = 4'd0; ID_WE = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    WB_WE = 1'b1; WB_A = 4'd3; WB_D = 32'h5;
    MC_Start = 1'b0; MC_Rd = 4'd0; MC_Done = 1'b0; MC_Result = 32'd0;
    clear_id();

    // reset gating
    settle();
    chk_wr("rst", 1'b0, 4'd0, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    chk("rst_busy", {31'd0, MC_Busy}, 32'd0);
    tick(); tick();
    Reset = 1'b0; WB_WE = 1'b0; WB_A = 4'd0; WB_D = 32'd0;
    tick();
    chk_wr("post_rst", 1'b0, 4'd0, 32'd0);
    chk("post_rst_err", {31'd0, Err}, 32'd0);
    chk("post_rst_busy", {31'd0, MC_Busy}, 32'd0);
    chk("post_rst_stall", {31'd0, Stall}, 32'd0);

    // no collision
    MC_Start = 1'b1; MC_Rd = 4'd5; ID_RE1 = 1'b1; ID_A1 = 4'd5;
    settle();
    chk("nc_stall_start", {31'd0, Stall}, 32'd0);
    tick();
    MC_Start = 1'b0;
    settle();
    chk("nc_busy", {31'd0, MC_Busy}, 32'd1);
    chk("nc_stall_busy", {31'd0, Stall}, 32'd1);
    tick(); tick();
    MC_Done = 1'b1; MC_Result = 32'hDEADBEEF;
    settle();
    chk_wr("nc_wr", 1'b1, 4'd5, 32'hDEADBEEF);
    chk("nc_stall_wr", {31'd0, Stall}, 32'd1);
    tick();
    MC_Done = 1'b0;
    settle();
    chk("nc_stall_after", {31'd0, Stall}, 32'd0);
    chk("nc_busy_after", {31'd0, MC_Busy}, 32'd0);
    chk("nc_we_after", {31'd0, WE3}, 32'd0);

    // collision then drain
    clear_id();
    MC_Start = 1'b1; MC_Rd = 4'd9;
    tick();
    MC_Start = 1'b0;
    tick();
    MC_Done = 1'b1; MC_Result = 32'hCAFE0001;
    WB_WE = 1'b1; WB_A = 4'd2; WB_D = 32'h11;
    settle();
    chk_wr("col_main", 1'b1, 4'd2, 32'h11);
    tick();
    MC_Done = 1'b0; WB_WE = 1'b0; ID_RE1 = 1'b1; ID_A1 = 4'd9;
    settle();
    chk("col_hold_busy", {31'd0, MC_Busy}, 32'd1);
    chk_wr("col_drain", 1'b1, 4'd9, 32'hCAFE0001);
    chk("col_stall_drain", {31'd0, Stall}, 32'd1);
    tick();
    settle();
    chk("col_idle", {31'd0, MC_Busy}, 32'd0);
    chk("col_stall_after", {31'd0, Stall}, 32'd0);
    chk("col_we_after", {31'd0, WE3}, 32'd0);

    // starvation guard
    clear_id();
    MC_Start = 1'b1; MC_Rd = 4'd4;
    tick();
    MC_Start = 1'b0;
    MC_Done = 1'b1; MC_Result = 32'h44444444;
    WB_WE = 1'b1; WB_A = 4'd1; WB_D = 32'h1;
    tick();
    MC_Done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk($sformatf("starve_stall_%0d", i), {31'd0, Stall}, {31'd0, (i >= 4)});
      chk($sformatf("starve_a3_%0d", i), {28'd0, A3}, 32'd1);
      tick();
    end
    WB_WE = 1'b0;
    settle();
    chk_wr("starve_drain", 1'b1, 4'd4, 32'h44444444);
    chk("starve_stall_drain", {31'd0, Stall}, 32'd1);
    tick();
    settle();
    chk("starve_idle", {31'd0, MC_Busy}, 32'd0);
    chk("starve_stall_after", {31'd0, Stall}, 32'd0);

    // hazards and MC_Start while busy
    MC_Start = 1'b1; MC_Rd = 4'd7;
    tick();
    MC_Start = 1'b0;
    ID_WE = 1'b1; ID_Wr = 4'd7;
    settle();
    chk("haz_waw", {31'd0, Stall}, 32'd1);
    ID_WE = 1'b0; ID_RE1 = 1'b1; ID_A1 = 4'd15;
    settle();
    chk("haz_r15", {31'd0, Stall}, 32'd0);
    ID_RE1 = 1'b0; ID_RE2 = 1'b1; ID_A2 = 4'd7;
    settle();
    chk("haz_raw2", {31'd0, Stall}, 32'd1);
    clear_id();
    MC_Start = 1'b1; MC_Rd = 4'd3;
    settle();
    chk("err_before", {31'd0, Err}, 32'd0);
    tick();
    MC_Start = 1'b0; ID_RE1 = 1'b1; ID_A1 = 4'd3;
    settle();
    chk("err_busy_start", {31'd0, Err}, 32'd1);
    chk("err_no_pend3", {31'd0, Stall}, 32'd0);
    ID_A1 = 4'd7;
    settle();
    chk("err_pend7_kept", {31'd0, Stall}, 32'd1);
    tick();
    settle();
    chk("err_pulse_end", {31'd0, Err}, 32'd0);
    clear_id();
    MC_Done = 1'b1; MC_Result = 32'h77;
    settle();
    chk_wr("err_rdq_kept", 1'b1, 4'd7, 32'h77);
    tick();
    MC_Done = 1'b0;

    // destination R15
    MC_Start = 1'b1; MC_Rd = 4'd15;
    tick();
    MC_Start = 1'b0;
    ID_RE1 = 1'b1; ID_A1 = 4'd15; ID_WE = 1'b1; ID_Wr = 4'd15;
    settle();
    chk("r15_busy", {31'd0, MC_Busy}, 32'd1);
    chk("r15_stall", {31'd0, Stall}, 32'd0);
    MC_Done = 1'b1; MC_Result = 32'h99;
    settle();
    chk("r15_no_write", {31'd0, WE3}, 32'd0);
    tick();
    MC_Done = 1'b0;
    clear_id();
    settle();
    chk("r15_idle", {31'd0, MC_Busy}, 32'd0);

    // MC_Done while idle
    MC_Done = 1'b1; MC_Result = 32'h55;
    settle();
    chk("idle_done_we", {31'd0, WE3}, 32'd0);
    tick();
    MC_Done = 1'b0;
    settle();
    chk("idle_done_err", {31'd0, Err}, 32'd1);
    chk("idle_done_busy", {31'd0, MC_Busy}, 32'd0);
    tick();
    settle();
    chk("idle_done_err_end", {31'd0, Err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
